// File: rtl/test_value_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : test_value_uart_reporter
// Purpose  : Sends the 16-bit probe word as "HHHH\r\n" over 8N1 UART whenever
//            the word changes or a send is forced.
// Revision : 1.0 - initial release
// ============================================================================
module test_value_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] test_value,
    input  logic        force_send,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] c_bit_last = 16'(CLKS_PER_BIT - 1);

    state_t      r_state,     w_state_nx;
    logic [15:0] r_timer,     w_timer_nx;
    logic [2:0]  r_bit_idx,   w_bit_idx_nx;
    logic [2:0]  r_char_idx,  w_char_idx_nx;
    logic [15:0] r_shadow;
    logic [15:0] r_last_sent;
    logic [15:0] r_prev_value;
    logic [7:0]  r_drop_count;
    logic        w_load;
    logic        w_bit_end;
    logic [3:0]  w_nibble;
    logic [7:0]  w_char;

    assign w_bit_end = (r_timer == c_bit_last);

    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer;
        w_bit_idx_nx  = r_bit_idx;
        w_char_idx_nx = r_char_idx;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nx = 16'd0;
                if ((test_value != r_last_sent) || force_send) begin
                    w_load        = 1'b1;
                    w_state_nx    = ST_START;
                    w_char_idx_nx = 3'd0;
                    w_bit_idx_nx  = 3'd0;
                end
            end
            ST_START: begin
                w_timer_nx = w_bit_end ? 16'd0 : r_timer + 16'd1;
                if (w_bit_end) begin
                    w_state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                w_timer_nx = w_bit_end ? 16'd0 : r_timer + 16'd1;
                if (w_bit_end) begin
                    w_bit_idx_nx = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                w_timer_nx = w_bit_end ? 16'd0 : r_timer + 16'd1;
                if (w_bit_end) begin
                    if (r_char_idx == 3'd5) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_char_idx_nx = r_char_idx + 3'd1;
                        w_state_nx    = ST_START;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Character generator: four hex digits of the snapshot, then CR, LF.
    always_comb begin
        w_nibble = 4'd0;
        w_char   = 8'h0A;
        case (r_char_idx[1:0])
            2'd0:    w_nibble = r_shadow[15:12];
            2'd1:    w_nibble = r_shadow[11:8];
            2'd2:    w_nibble = r_shadow[7:4];
            default: w_nibble = r_shadow[3:0];
        endcase
        if (r_char_idx == 3'd4) begin
            w_char = 8'h0D;
        end else if (r_char_idx == 3'd5) begin
            w_char = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_char = 8'h30 + {4'd0, w_nibble};
        end else begin
            w_char = 8'h37 + {4'd0, w_nibble};
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = w_char[r_bit_idx];
            default:  tx = 1'b1;
        endcase
    end

    assign busy       = (r_state != ST_IDLE);
    assign drop_count = r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_timer      <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_char_idx   <= 3'd0;
            r_shadow     <= 16'h0000;
            r_last_sent  <= 16'h0000;
            r_prev_value <= 16'h0000;
            r_drop_count <= 8'd0;
        end else begin
            r_state      <= w_state_nx;
            r_timer      <= w_timer_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_char_idx   <= w_char_idx_nx;
            r_prev_value <= test_value;
            if (w_load) begin
                r_shadow    <= test_value;
                r_last_sent <= test_value;
            end
            // Values that change under an in-flight frame are lost; count them.
            if (busy && (test_value != r_prev_value) && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_value_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_value_uart_reporter
// Purpose  : Scoreboard bench: stimulus queues expected UART bytes, a decoder
//            process pops and compares them as frames appear on tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_value_uart_reporter;

    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic [15:0] test_value;
    logic        force_send;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_count;

    int          total_checks = 0;
    int          passed_checks = 0;
    logic [7:0]  exp_q[$];
    int          idle_tx_err = 0;
    int          wrap_err = 0;
    bit          wrap_watch = 0;

    test_value_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .test_value (test_value),
        .force_send (force_send),
        .tx         (tx),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
        exp_q.push_back(c3);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'(0));
    endtask

    task automatic quiet_cycles(input int n, input string name);
        int viol = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) viol++;
        end
        check(name, 32'(viol), 32'(0));
    endtask

    // UART decoder: samples mid-bit, abandons a byte if reset is seen.
    task automatic rx_byte();
        logic [7:0] data = 8'h00;
        logic       stop_b = 1'b0;
        bit         aborted = 1'b0;
        logic [7:0] e;
        for (int c = 1; c <= 9*CPB + CPB/2; c++) begin
            @(negedge clk);
            if (reset) begin
                aborted = 1'b1;
                break;
            end
            if (c == 9*CPB + CPB/2) stop_b = tx;
            else if (c >= CPB + CPB/2 && ((c - CPB - CPB/2) % CPB) == 0) data = {tx, data[7:1]};
        end
        if (!aborted) begin
            check("stop_bit", 32'(stop_b), 32'(1));
            if (exp_q.size() == 0) begin
                total_checks++;
                $display("FAIL unexpected_byte: got %0h expected none", data);
            end else begin
                e = exp_q.pop_front();
                check("uart_byte", 32'(data), 32'(e));
            end
        end
    endtask

    initial begin : uart_monitor
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) rx_byte();
        end
    end

    initial begin : busy_monitor
        int  run = 0;
        bit  aborted = 1'b0;
        logic [7:0] last_drop = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) aborted = 1'b1;
            if (!busy && tx !== 1'b1) idle_tx_err++;
            if (wrap_watch && drop_count < last_drop) wrap_err++;
            last_drop = drop_count;
            if (busy) run++;
            else begin
                if (run != 0 && !aborted) check("busy_len", 32'(run), 32'(60*CPB));
                run = 0;
                aborted = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1;
        test_value = 16'h00A5;
        force_send = 1'b0;

        // Frame on first cycle after reset for a nonzero word
        push_frame(8'h30, 8'h30, 8'h41, 8'h35);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'(1));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_drop", 32'(drop_count), 32'(0));
        @(posedge clk); #1;
        check("start_tx", 32'(tx), 32'(0));
        check("start_busy", 32'(busy), 32'(1));
        wait_idle(300, "t1");
        check("t1_drop", 32'(drop_count), 32'(0));

        // Zero word after reset: silent until forced; force while busy ignored
        @(posedge clk); #1 reset = 1'b1; test_value = 16'h0000;
        @(posedge clk); #1 reset = 1'b0;
        quiet_cycles(1000, "zero_silent");
        @(posedge clk); #1 force_send = 1'b1;
        push_frame(8'h30, 8'h30, 8'h30, 8'h30);
        @(posedge clk); #1 force_send = 1'b0;
        check("force_busy", 32'(busy), 32'(1));
        repeat (100) @(posedge clk);
        #1 force_send = 1'b1;
        @(posedge clk); #1 force_send = 1'b0;
        wait_idle(300, "t2");
        quiet_cycles(300, "force_ignored");

        // Changes mid-frame: frame unaltered, latest value follows after one idle cycle
        @(posedge clk); #1 test_value = 16'h1234;
        push_frame(8'h31, 8'h32, 8'h33, 8'h34);
        repeat (50) @(posedge clk);
        #1 test_value = 16'hBEEF;
        repeat (50) @(posedge clk);
        #1 test_value = 16'hCAFE;
        push_frame(8'h43, 8'h41, 8'h46, 8'h45);
        wait_idle(300, "t3a");
        check("t3_drop", 32'(drop_count), 32'(2));
        @(negedge clk);
        check("one_idle_gap", 32'(busy), 32'(1));
        wait_idle(300, "t3b");

        // Value returns to last_sent mid-frame: no second frame
        @(posedge clk); #1 test_value = 16'h00A5;
        push_frame(8'h30, 8'h30, 8'h41, 8'h35);
        repeat (30) @(posedge clk);
        #1 test_value = 16'h1234;
        repeat (30) @(posedge clk);
        #1 test_value = 16'h00A5;
        wait_idle(300, "t4");
        check("t4_drop", 32'(drop_count), 32'(4));
        quiet_cycles(300, "t4_no_resend");

        // Reset mid-frame abandons the frame; nonzero word restarts right away
        @(posedge clk); #1 test_value = 16'h0001;
        push_frame(8'h30, 8'h30, 8'h30, 8'h31);
        repeat (70) @(posedge clk);
        #1 reset = 1'b1; test_value = 16'hFFFF;
        exp_q.delete();
        push_frame(8'h46, 8'h46, 8'h46, 8'h46);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_tx", 32'(tx), 32'(1));
        check("midreset_busy", 32'(busy), 32'(0));
        check("midreset_drop", 32'(drop_count), 32'(0));
        @(posedge clk); #1;
        check("restart_tx", 32'(tx), 32'(0));
        check("restart_busy", 32'(busy), 32'(1));
        wait_idle(300, "t5");

        // Toggle every cycle across two frames: drop_count saturates at 255
        @(posedge clk); #1 test_value = 16'h0F0F;
        push_frame(8'h30, 8'h46, 8'h30, 8'h46);
        push_frame(8'h46, 8'h30, 8'h46, 8'h30);
        push_frame(8'h30, 8'h46, 8'h30, 8'h46);
        wrap_watch = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1 test_value = (k % 2 == 1) ? 16'hF0F0 : 16'h0F0F;
        end
        wait_idle(300, "t6b");
        @(negedge clk);
        check("t6_third_frame", 32'(busy), 32'(1));
        wait_idle(300, "t6c");
        check("t6_drop_sat", 32'(drop_count), 32'(255));
        wrap_watch = 1'b0;

        repeat (5) @(negedge clk);
        check("drop_no_wrap", 32'(wrap_err), 32'(0));
        check("idle_tx_high", 32'(idle_tx_err), 32'(0));
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
`default_nettype wire
